// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one line-wide memory port between the I-cache and D-cache engines.
// Define ARB_DCACHE_PRIO_EN for fixed D-cache priority on contention; the default build is round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  i_txn_cnt,
    output logic [CNT_W-1:0]  d_txn_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state;
    logic   owner_d;
    logic   last_d;
    logic   i_req;
    logic   d_req;
    logic   grant_d;
    logic   d_is_write;

    assign i_req      = i_read;
    assign d_req      = d_read | d_write;
    assign d_is_write = grant_d & d_write;

    // last_d low means the I-cache was served last, so the D-cache wins the next tie.
    always_comb begin
`ifdef ARB_DCACHE_PRIO_EN
        grant_d = d_req;
`else
        grant_d = d_req & (~i_req | ~last_d);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_txn_cnt <= '0;
            d_txn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_d   <= grant_d;
                        mem_read  <= ~d_is_write;
                        mem_write <= d_is_write;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        if (d_is_write) begin
                            mem_wdata <= d_wdata;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Write completions leave the owner's rdata untouched.
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        last_d    <= owner_d;
                        if (owner_d) begin
                            d_ready <= 1'b1;
                            if (!mem_write) begin
                                d_rdata <= mem_rdata;
                            end
                            if (d_txn_cnt != '1) begin
                                d_txn_cnt <= d_txn_cnt + CNT_W'(1);
                            end
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                            if (i_txn_cnt != '1) begin
                                i_txn_cnt <= i_txn_cnt + CNT_W'(1);
                            end
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level arbitration model.
// Honours ARB_DCACHE_PRIO_EN when predicting which requester wins a tie.
module tb_mem_arbiter;

    localparam int ADDR_W  = 28;
    localparam int DATA_W  = 128;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  i_txn_cnt;
    logic [CNT_W-1:0]  d_txn_cnt;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .i_txn_cnt(i_txn_cnt), .d_txn_cnt(d_txn_cnt)
    );

    typedef struct packed {
        logic              owner;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en;
    bit   mem_auto;
    int   mem_lat;
    bit   model_last;
    int   last_strobe_cycles;
    logic [3:0] grant_bits;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] mem_func(input logic [ADDR_W-1:0] a);
        if (a == 28'h0000010) return {96'h0, 32'hDEADBEEF};
        return {4{4'hA, a}};
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Memory: acknowledges after the strobe has been high for mem_lat+1 cycles.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!mem_auto || rst) begin
                cnt = 0;
                if (mem_auto) mem_ready = 1'b0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end else if (mem_read || mem_write) begin
                cnt++;
                if (cnt > mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_func(mem_addr);
                end
            end
        end
    end

    // Monitor: pops an expectation when a memory transaction starts, checks it at the ready pulse.
    initial begin
        txn_t cur;
        bit   in_txn = 0;
        int   strobes = 0;
        int   cnt_i = 0;
        int   cnt_d = 0;
        logic [DATA_W-1:0] exp_i_rdata = '0;
        logic [DATA_W-1:0] exp_d_rdata = '0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_txn = 0; strobes = 0; cnt_i = 0; cnt_d = 0;
                exp_i_rdata = '0; exp_d_rdata = '0; grant_bits = '0;
            end else if (mon_en) begin
                if (mem_read || mem_write) begin
                    if (!in_txn) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("unexpected_strobe", {mem_read, mem_write}, 0);
                            cur = '0;
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        in_txn = 1;
                        strobes = 0;
                    end
                    strobes++;
                    checkOutput("mem_read", mem_read, !cur.wr);
                    checkOutput("mem_write", mem_write, cur.wr);
                    checkOutput("mem_addr", mem_addr, cur.addr);
                    if (cur.wr) checkOutput("mem_wdata", mem_wdata, cur.wdata);
                end
                if (i_ready || d_ready) begin
                    if (!in_txn) begin
                        checkOutput("ready_without_txn", {i_ready, d_ready}, 0);
                    end else begin
                        checkOutput("i_ready", i_ready, !cur.owner);
                        checkOutput("d_ready", d_ready, cur.owner);
                        if (cur.owner) begin
                            if (!cur.wr) exp_d_rdata = mem_func(cur.addr);
                            if (cnt_d < CNT_MAX) cnt_d++;
                        end else begin
                            exp_i_rdata = mem_func(cur.addr);
                            if (cnt_i < CNT_MAX) cnt_i++;
                        end
                        checkOutput("i_rdata", i_rdata, exp_i_rdata);
                        checkOutput("d_rdata", d_rdata, exp_d_rdata);
                        checkOutput("i_txn_cnt", i_txn_cnt, cnt_i);
                        checkOutput("d_txn_cnt", d_txn_cnt, cnt_d);
                        grant_bits = {grant_bits[2:0], cur.owner};
                        last_strobe_cycles = strobes;
                        in_txn = 0;
                    end
                end
            end
        end
    end

    task automatic doReset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        model_last = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Raises the requested lines, predicts service order and holds each request until its ready pulse.
    task automatic applyStimulus(input bit ion, input bit dr, input bit dw,
                                 input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                                 input logic [DATA_W-1:0] dwd);
        txn_t ti, td;
        bit   i_pend, d_pend, drop_i, drop_d, d_first;
        int   budget = 200;
        ti = '{owner: 1'b0, wr: 1'b0, addr: ia, wdata: '0};
        td = '{owner: 1'b1, wr: dw, addr: da, wdata: dwd};
        i_pend = ion;
        d_pend = dr | dw;
        if (i_pend && d_pend) begin
`ifdef ARB_DCACHE_PRIO_EN
            d_first = 1'b1;
`else
            d_first = (model_last == 1'b0);
`endif
            if (d_first) begin
                exp_q.push_back(td); exp_q.push_back(ti); model_last = 1'b0;
            end else begin
                exp_q.push_back(ti); exp_q.push_back(td); model_last = 1'b1;
            end
        end else if (i_pend) begin
            exp_q.push_back(ti); model_last = 1'b0;
        end else if (d_pend) begin
            exp_q.push_back(td); model_last = 1'b1;
        end
        i_addr = ia; d_addr = da; d_wdata = dwd;
        i_read = ion; d_read = dr; d_write = dw;
        while ((i_pend || d_pend) && budget > 0) begin
            @(negedge clk);
            drop_i = i_pend && i_ready;
            drop_d = d_pend && d_ready;
            @(posedge clk);
            #1;
            if (drop_i) begin i_read = 1'b0; i_pend = 0; end
            if (drop_d) begin d_read = 1'b0; d_write = 1'b0; d_pend = 0; end
            budget--;
        end
        if (i_pend || d_pend) begin
            checkOutput("ready_timeout", {i_pend, d_pend}, 0);
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] ra, rd;
        int kind;
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        mon_en = 1; mem_auto = 1; mem_lat = 3; model_last = 1'b0;
        last_strobe_cycles = 0; grant_bits = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_read", mem_read, 0);
        checkOutput("rst_mem_write", mem_write, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_i_ready", i_ready, 0);
        checkOutput("rst_d_ready", d_ready, 0);
        checkOutput("rst_i_rdata", i_rdata, 0);
        checkOutput("rst_d_rdata", d_rdata, 0);
        checkOutput("rst_i_cnt", i_txn_cnt, 0);
        checkOutput("rst_d_cnt", d_txn_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single I read");
        mem_lat = 3;
        applyStimulus(1, 0, 0, 28'h0000010, 28'h0000000, '0);
        checkOutput("i_read_strobe_cycles", last_strobe_cycles, 4);
        checkOutput("i_rdata_deadbeef", i_rdata, {96'h0, 32'hDEADBEEF});

        $display("[TB] single D write");
        mem_lat = 2;
        applyStimulus(0, 0, 1, 28'h0000000, 28'h0000020,
                      128'h12345678_9ABCDEF0_0F1E2D3C_4B5A5678);
        checkOutput("d_rdata_after_write", d_rdata, 0);
        checkOutput("d_cnt_after_write", d_txn_cnt, 1);

        $display("[TB] contention order");
        doReset();
        mem_lat = 1;
        applyStimulus(1, 1, 0, 28'h0000100, 28'h0000200, '0);
        applyStimulus(1, 1, 0, 28'h0000300, 28'h0000400, '0);
        checkOutput("grant_order", grant_bits, 4'b1010);

        $display("[TB] read and write together");
        applyStimulus(0, 1, 1, 28'h0, 28'h0000555, 128'hCAFE);

        $display("[TB] reset during busy");
        mon_en = 0; mem_auto = 0; mem_ready = 1'b0;
        i_addr = 28'h0000040; i_read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort_strobe_before", mem_read, 1);
        rst = 1'b1; i_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1; mem_rdata = '1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("abort_ready", {i_ready, d_ready}, 0);
            checkOutput("abort_strobes", {mem_read, mem_write}, 0);
            checkOutput("abort_counters", {i_txn_cnt, d_txn_cnt}, 0);
            checkOutput("abort_i_rdata", i_rdata, 0);
        end
        @(posedge clk); #1;
        model_last = 1'b0; exp_q.delete();
        mon_en = 1; mem_auto = 1;

        $display("[TB] counter saturation");
        doReset();
        for (int k = 0; k < 5; k++) begin
            mem_lat = k % 3;
            applyStimulus(1, 0, 0, 28'(k * 16 + 7), 28'h0, '0);
        end
        checkOutput("i_cnt_saturated", i_txn_cnt, 3);

        $display("[TB] random traffic");
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(1, 7);
            ra = ADDR_W'($urandom);
            rd = ADDR_W'($urandom);
            if (rd == ra) rd = rd ^ 28'h1;
            mem_lat = $urandom_range(0, 4);
            applyStimulus(kind[0], kind[1], kind[2], ra, rd,
                          {$urandom, $urandom, $urandom, $urandom});
        end
        repeat (3) @(posedge clk);
        checkOutput("expectations_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter for the RISC-V core: shares the single 128-bit off-chip memory port between the I-cache and D-cache miss/write-back engines. It serialises one block transaction at a time, buffers the returned line, and issues a one-cycle ready pulse to the owner. It also keeps per-requester transaction counters for cycle/traffic profiling during testbench runs.

## Interface
Parameters:
- ADDR_W, 28, block address width (word address >> 2)
- DATA_W, 128, cache line width
- CNT_W, 16, transaction counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request, held until i_ready
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  DATA_W  line returned to I-cache
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_ready
- d_write  in  1  D-cache write-back request, held until d_ready
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  DATA_W  D-cache write-back line
- d_rdata  out  DATA_W  line returned to D-cache
- d_ready  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one cycle
- i_txn_cnt  out  CNT_W  completed I-cache transactions
- d_txn_cnt  out  CNT_W  completed D-cache transactions

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: sample requests. None -> stay. One -> grant it. Both -> policy (below). Latch owner, op, mem_addr, mem_wdata; go BUSY.
- Default policy: round-robin on `last` bit; grant the requester not granted last. `last` resets to I, so D wins the first contention.
- d_read and d_write both high: treated as write.
- BUSY: mem_read/mem_write held at latched value, mem_addr/mem_wdata stable. On mem_ready: capture mem_rdata into owner's rdata register (reads only), update `last`, increment owner's counter, go DONE.
- DONE: mem_read=mem_write=0; owner's x_ready=1 for this cycle only; go IDLE.
- Requester inputs are ignored outside IDLE; non-owner requests wait.
- Counters saturate at all-ones (no wrap).
- i_rdata/d_rdata hold last captured line until overwritten; write completions leave d_rdata unchanged.

## Timing
- Reset: state IDLE, last=I, all outputs 0 (strobes, ready, addr, wdata, rdata, counters).
- Request seen at edge N -> mem strobe high from cycle N+1.
- mem_ready at edge M -> x_ready high in cycle M+1 exactly one cycle, rdata valid same cycle.
- Minimum turnaround: request-to-ready = memory latency + 2 cycles.
- Requester must drop its request on the edge ending its ready cycle; IDLE then samples fresh requests (one idle cycle between back-to-back transactions).
- mem_ready outside BUSY is ignored.
- rst asserted mid-transaction: abort immediately, all outputs to reset values next cycle; in-flight memory completion is dropped.

## Configuration
- ARB_DCACHE_PRIO_EN defined: fixed priority, D-cache always wins contention; `last` still tracked but unused.
- Undefined: round-robin as above.

## Test plan
- Single I read, addr 0x0000010, memory latency 3, rdata 0x…DEADBEEF -> mem_read high 4 cycles, i_ready one pulse, i_rdata=0x…DEADBEEF, i_txn_cnt=1.
- Single D write, addr 0x0000020, wdata 0x1234…5678 -> mem_write with that addr/data until mem_ready, d_ready one pulse, d_rdata unchanged, d_txn_cnt=1.
- Simultaneous I and D reads held continuously for 4 transactions -> grant order D,I,D,I (order D,D,D,D with ARB_DCACHE_PRIO_EN while D keeps requesting and I starves).
- d_read=d_write=1 -> mem_write asserted, mem_read 0.
- rst pulsed during BUSY, then mem_ready arrives -> no ready pulse, counters 0, strobes 0.
- Counter saturation (CNT_W forced 2 in bench): 5 I transactions -> i_txn_cnt=3.
